// File: rtl/spill_pkg.sv
// spill_pkg: shared defaults, state encoding and limits for the register spill store engine
package spill_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RF_AW  = 4;
    localparam int DEF_DM_AW  = 8;
    localparam int MAX_COUNT  = 16;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} spill_state_t;
endpackage

// File: rtl/reg_spill_store.sv
// reg_spill_store: streams consecutive register-file entries into consecutive data-memory words; optional constant fill via SPILL_FILL_EN
module reg_spill_store
    import spill_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RF_AW  = DEF_RF_AW,
    parameter int DM_AW  = DEF_DM_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [RF_AW-1:0]  src_reg,
    input  logic [DM_AW-1:0]  dst_addr,
    input  logic [RF_AW:0]    count,
`ifdef SPILL_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output logic [RF_AW-1:0]  rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [DATA_W-1:0] dm_data,
    output logic              dm_wren
);
    localparam logic [RF_AW:0] CNT_MAX = (RF_AW+1)'(MAX_COUNT);
    spill_state_t state;
    logic [DM_AW-1:0] wr_addr;
    logic [RF_AW:0] remaining;
    logic [RF_AW:0] sat_count;
    logic [DATA_W-1:0] word;
    logic fill_q;
    logic [DATA_W-1:0] fill_d;
    assign sat_count = count > CNT_MAX ? CNT_MAX : count;
    assign word = fill_q ? fill_d : rf_rd_data;
`ifdef SPILL_FILL_EN
    // latch the fill selection and pattern together with the command
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_q <= 1'b0;
            fill_d <= '0;
        end else if (state == IDLE && start) begin
            fill_q <= fill_en;
            fill_d <= fill_data;
        end
    end
`else
    assign fill_q = 1'b0;
    assign fill_d = '0;
`endif
    // command FSM: capture one word per RUN edge, present the last one in FLUSH
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            dm_wren    <= 1'b0;
            dm_addr    <= '0;
            dm_data    <= '0;
            rf_rd_addr <= '0;
            wr_addr    <= '0;
            remaining  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rf_rd_addr <= src_reg;
                        wr_addr    <= dst_addr;
                        remaining  <= sat_count;
                        busy       <= 1'b1;
                        dm_wren    <= 1'b0;
                        state      <= sat_count == '0 ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    dm_data    <= word;
                    dm_addr    <= wr_addr;
                    dm_wren    <= 1'b1;
                    wr_addr    <= wr_addr + DM_AW'(1);
                    rf_rd_addr <= rf_rd_addr + RF_AW'(1);
                    remaining  <= remaining - (RF_AW+1)'(1);
                    if (remaining == (RF_AW+1)'(1)) state <= FLUSH;
                end
                FLUSH: begin
                    dm_wren <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_spill_store.sv
// tb_reg_spill_store: directed checks of the spill store engine against a register-file and memory model
module tb_reg_spill_store;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic [3:0] src_reg = '0;
    logic [7:0] dst_addr = '0;
    logic [4:0] count = '0;
    logic busy, done, dm_wren;
    logic [3:0] rf_rd_addr;
    logic [15:0] rf_rd_data, dm_data;
    logic [7:0] dm_addr;
`ifdef SPILL_FILL_EN
    logic fill_en = 1'b0;
    logic [15:0] fill_data = '0;
`endif
    logic [15:0] rf [16];
    logic [15:0] mem [256];
    logic mem_clr = 1'b1;
    int total = 0, bad = 0;
    int busy_n = 0, wren_n = 0, done_n = 0;
    int b0, w0, d0;

    reg_spill_store dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_reg(src_reg),
        .dst_addr(dst_addr), .count(count),
`ifdef SPILL_FILL_EN
        .fill_en(fill_en), .fill_data(fill_data),
`endif
        .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .dm_addr(dm_addr), .dm_data(dm_data), .dm_wren(dm_wren)
    );

    always #5 clk = ~clk;
    assign rf_rd_data = rf[rf_rd_addr];

    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (dm_wren) mem[dm_addr] <= dm_data;
    end

    always @(negedge clk) begin
        busy_n <= busy_n + int'(busy);
        wren_n <= wren_n + int'(dm_wren);
        done_n <= done_n + int'(done);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [3:0] s, input logic [7:0] d, input logic [4:0] c);
        @(posedge clk);
        #1 src_reg = s; dst_addr = d; count = c; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic snap();
        @(negedge clk);
        b0 = busy_n; w0 = wren_n; d0 = done_n;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h5000 + 16'(i);
        rf[1] = 16'hAAAA; rf[2] = 16'hBBBB; rf[3] = 16'hCCCC;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wren", 32'(dm_wren), 0);
        chk("rst_addr", 32'(dm_addr), 0);
        chk("rst_data", 32'(dm_data), 0);
        chk("rst_rfaddr", 32'(rf_rd_addr), 0);

        snap();
        go(4'd1, 8'h10, 5'd3);
        wait_done("t1_done");
        settle();
        chk("t1_m10", 32'(mem[8'h10]), 32'hAAAA);
        chk("t1_m11", 32'(mem[8'h11]), 32'hBBBB);
        chk("t1_m12", 32'(mem[8'h12]), 32'hCCCC);
        chk("t1_m13", 32'(mem[8'h13]), 0);
        chk("t1_busy", 32'(busy_n - b0), 4);
        chk("t1_wren", 32'(wren_n - w0), 3);
        chk("t1_dpulse", 32'(done_n - d0), 1);

        snap();
        go(4'd14, 8'hFE, 5'd4);
        wait_done("t2_done");
        settle();
        chk("t2_mFE", 32'(mem[8'hFE]), 32'h500E);
        chk("t2_mFF", 32'(mem[8'hFF]), 32'h500F);
        chk("t2_m00", 32'(mem[8'h00]), 32'h5000);
        chk("t2_m01", 32'(mem[8'h01]), 32'hAAAA);
        chk("t2_wren", 32'(wren_n - w0), 4);

        snap();
        go(4'd5, 8'h30, 5'd0);
        @(negedge clk);
        chk("t3_busy1", 32'(busy), 1);
        chk("t3_done0", 32'(done), 0);
        @(negedge clk);
        chk("t3_done1", 32'(done), 1);
        chk("t3_busy0", 32'(busy), 0);
        settle();
        chk("t3_wren", 32'(wren_n - w0), 0);
        chk("t3_bcnt", 32'(busy_n - b0), 1);

        snap();
        go(4'd0, 8'h40, 5'd20);
        wait_done("t4_done");
        settle();
        chk("t4_wren", 32'(wren_n - w0), 16);
        chk("t4_busy", 32'(busy_n - b0), 17);
        chk("t4_m40", 32'(mem[8'h40]), 32'h5000);
        chk("t4_m4F", 32'(mem[8'h4F]), 32'h500F);
        chk("t4_m50", 32'(mem[8'h50]), 0);

        snap();
        go(4'd2, 8'h80, 5'd4);
        @(posedge clk);
        @(posedge clk);
        #1 src_reg = 4'd9; dst_addr = 8'h90; count = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5_doneA");
        src_reg = 4'd5; dst_addr = 8'hA0; count = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("t5_nogap", 32'(busy), 1);
        wait_done("t5_doneB");
        settle();
        chk("t5_m80", 32'(mem[8'h80]), 32'hBBBB);
        chk("t5_m83", 32'(mem[8'h83]), 32'h5005);
        chk("t5_m90", 32'(mem[8'h90]), 0);
        chk("t5_mA0", 32'(mem[8'hA0]), 32'h5005);
        chk("t5_mA1", 32'(mem[8'hA1]), 32'h5006);
        chk("t5_wren", 32'(wren_n - w0), 6);
        chk("t5_busy", 32'(busy_n - b0), 8);
        chk("t5_dcnt", 32'(done_n - d0), 2);

        go(4'd0, 8'hC0, 5'd5);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_wren", 32'(dm_wren), 0);
        chk("t6_addr", 32'(dm_addr), 0);
        chk("t6_data", 32'(dm_data), 0);
        chk("t6_rfaddr", 32'(rf_rd_addr), 0);
        snap();
        @(posedge clk);
        #1 reset_n = 1'b1;
        settle();
        chk("t6_nowr", 32'(wren_n - w0), 0);
        chk("t6_mC0", 32'(mem[8'hC0]), 32'h5000);
        chk("t6_mC1", 32'(mem[8'hC1]), 32'hAAAA);
        chk("t6_mC2", 32'(mem[8'hC2]), 0);

`ifdef SPILL_FILL_EN
        go(4'd0, 8'hD0, 5'd8);
        wait_done("t7_pre");
        settle();
        snap();
        fill_en = 1'b1; fill_data = 16'h0000;
        go(4'd3, 8'hD0, 5'd8);
        fill_en = 1'b0; fill_data = 16'hFFFF;
        wait_done("t7_done");
        settle();
        chk("t7_wren", 32'(wren_n - w0), 8);
        chk("t7_mD0", 32'(mem[8'hD0]), 0);
        chk("t7_mD7", 32'(mem[8'hD7]), 0);
        chk("t7_mD8", 32'(mem[8'hD8]), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
